// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, read-FSM states and the octal digit-swap used to turn the
// radix-8 digit-reversed FFT64 output index into natural order.
package fft_out_reorder_pkg;

  localparam int LOG2_FFT = 6;
  localparam int DIGIT_WD = 3;

  typedef logic [LOG2_FFT-1:0] pt_idx_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic pt_idx_t digit_swap(input pt_idx_t idx);
    return {idx[DIGIT_WD-1:0], idx[LOG2_FFT-1:DIGIT_WD]};
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Two-bank frame buffer: one write port, one synchronous read port (1-cycle latency).
// The address MSB selects the bank.
module fft_reorder_ram #(
  parameter int DAT_WD  = 20,
  parameter int ADDR_WD = 7
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [ADDR_WD-1:0] wr_addr_i,
  input  logic [DAT_WD-1:0]  wr_dat_i,
  input  logic               rd_en_i,
  input  logic [ADDR_WD-1:0] rd_addr_i,
  output logic [DAT_WD-1:0]  rd_dat_o
);

  logic [DAT_WD-1:0] mem_q [2**ADDR_WD];

  // Storage array is not reset; only words written in the current frame are read back.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
    if (rd_en_i) begin
      rd_dat_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT64 output sink: ping-pong frame buffer with digit-swapped write addressing,
// a two-state read FSM and a 2-entry skid FIFO feeding a valid/ready stream.
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  parameter int FFT_DAT_WD = 10,
  parameter int SIZE_FFT   = 64,
  parameter bit REORDER_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic [FFT_DAT_WD-1:0] fft_dat_re_i,
  input  logic [FFT_DAT_WD-1:0] fft_dat_im_i,
  input  logic                  rdy_i,
  output logic                  vld_o,
  output logic [FFT_DAT_WD-1:0] fft_dat_re_o,
  output logic [FFT_DAT_WD-1:0] fft_dat_im_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  ovf_o
);

  localparam int      SMP_WD   = 2 * FFT_DAT_WD;
  localparam int      ENT_WD   = SMP_WD + 2;
  localparam pt_idx_t LAST_IDX = pt_idx_t'(SIZE_FFT - 1);

  pt_idx_t           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_idx_s;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic              drop_q, drop_d, ovf_q, ovf_d;
  logic [1:0]        full_q, full_d, full_set_s, full_clr_s;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic              infl_q, infl_d, infl_sof_q, infl_sof_d, infl_eof_q, infl_eof_d;
  logic [ENT_WD-1:0] skid0_q, skid0_d, skid1_q, skid1_d, ent_s;
  rd_state_e         rd_state_q, rd_state_d;
  logic              drop_s, wr_en_s, rd_go_s, rd_en_s, rd_last_s, pop_s;
  logic [LOG2_FFT:0] wr_addr_s, rd_addr_s;
  logic [SMP_WD-1:0] rd_dat_s;

  // Write side: a frame whose first sample finds its bank full is dropped in full,
  // but still counted so the next frame boundary stays aligned.
  always_comb begin
    drop_s     = (wr_cnt_q == 6'd0) ? full_q[wr_bank_q] : drop_q;
    wr_en_s    = vld_i && !drop_s;
    wr_idx_s   = REORDER_EN ? digit_swap(wr_cnt_q) : wr_cnt_q;
    wr_addr_s  = {wr_bank_q, wr_idx_s};
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = drop_q;
    ovf_d      = 1'b0;
    full_set_s = 2'b00;
    if (vld_i) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      drop_d   = drop_s;
      if (wr_cnt_q == LAST_IDX) begin
        ovf_d                  = drop_s;
        wr_bank_d              = drop_s ? wr_bank_q : ~wr_bank_q;
        full_set_s[wr_bank_q]  = !drop_s;
      end else begin
        ovf_d = 1'b0;
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // Read side: IDLE already issues read 0 when a bank is full, so a full frame
  // reaches the skid with no extra cycle; reads only go out if the skid has room.
  always_comb begin
    pop_s      = (skid_cnt_q != 2'd0) && rdy_i;
    rd_go_s    = (rd_state_q == RD_READ) || full_q[rd_bank_q];
    rd_en_s    = rd_go_s && ((skid_cnt_q + {1'b0, infl_q} - {1'b0, pop_s}) < 2'd2);
    rd_last_s  = rd_en_s && (rd_cnt_q == LAST_IDX);
    rd_addr_s  = {rd_bank_q, rd_cnt_q};
    rd_cnt_d   = rd_en_s ? rd_cnt_q + 6'd1 : rd_cnt_q;
    infl_d     = rd_en_s;
    infl_sof_d = rd_en_s && (rd_cnt_q == 6'd0);
    infl_eof_d = rd_last_s;
    rd_bank_d  = rd_bank_q;
    full_clr_s = 2'b00;
    case (rd_state_q)
      RD_IDLE: rd_state_d = full_q[rd_bank_q] ? RD_READ : RD_IDLE;
      RD_READ: rd_state_d = RD_READ;
      default: rd_state_d = RD_IDLE;
    endcase
    if (rd_last_s) begin
      full_clr_s[rd_bank_q] = 1'b1;
      rd_bank_d             = ~rd_bank_q;
      rd_state_d            = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
    end else begin
      rd_bank_d = rd_bank_q;
    end
    full_d = (full_q | full_set_s) & ~full_clr_s;
  end

  // Skid FIFO: head entry drives the outputs, so it only moves on a transfer.
  always_comb begin
    ent_s      = {rd_dat_s, infl_sof_q, infl_eof_q};
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({infl_q, pop_s})
      2'b10: begin
        skid_cnt_d = skid_cnt_q + 2'd1;
        if (skid_cnt_q == 2'd0) begin
          skid0_d = ent_s;
        end else begin
          skid1_d = ent_s;
        end
      end
      2'b01: begin
        skid_cnt_d = skid_cnt_q - 2'd1;
        skid0_d    = skid1_q;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = ent_s;
        end else begin
          skid0_d = skid1_q;
          skid1_d = ent_s;
        end
      end
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= 6'd0;
      wr_bank_q  <= 1'b0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      full_q     <= 2'b00;
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= 6'd0;
      rd_bank_q  <= 1'b0;
      infl_q     <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eof_q <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      full_q     <= full_d;
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      infl_q     <= infl_d;
      infl_sof_q <= infl_sof_d;
      infl_eof_q <= infl_eof_d;
      skid_cnt_q <= skid_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

  fft_reorder_ram #(
    .DAT_WD  (SMP_WD),
    .ADDR_WD (LOG2_FFT + 1)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_dat_i  ({fft_dat_re_i, fft_dat_im_i}),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (rd_addr_s),
    .rd_dat_o  (rd_dat_s)
  );

  assign vld_o        = (skid_cnt_q != 2'd0);
  assign fft_dat_re_o = skid0_q[ENT_WD-1 -: FFT_DAT_WD];
  assign fft_dat_im_o = skid0_q[2 +: FFT_DAT_WD];
  assign sof_o        = skid0_q[1];
  assign eof_o        = skid0_q[0];
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Drives one reordering and one pass-order instance with the same input stream and
// checks both against a frame-level model of the digit-swap reorder.
module tb_fft_out_reorder;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n, vld_i, rdy_i;
  logic [W-1:0] re_i, im_i;
  logic         vld_o [2];
  logic [W-1:0] re_o  [2];
  logic [W-1:0] im_o  [2];
  logic         sof_o [2];
  logic         eof_o [2];
  logic         ovf_o [2];

  always #5 clk = ~clk;

  fft_out_reorder #(.FFT_DAT_WD(W), .SIZE_FFT(64), .REORDER_EN(1'b1)) u_dut_reo (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .fft_dat_re_i(re_i), .fft_dat_im_i(im_i),
    .rdy_i(rdy_i), .vld_o(vld_o[0]), .fft_dat_re_o(re_o[0]), .fft_dat_im_o(im_o[0]),
    .sof_o(sof_o[0]), .eof_o(eof_o[0]), .ovf_o(ovf_o[0])
  );

  fft_out_reorder #(.FFT_DAT_WD(W), .SIZE_FFT(64), .REORDER_EN(1'b0)) u_dut_nat (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .fft_dat_re_i(re_i), .fft_dat_im_i(im_i),
    .rdy_i(rdy_i), .vld_o(vld_o[1]), .fft_dat_re_o(re_o[1]), .fft_dat_im_o(im_o[1]),
    .sof_o(sof_o[1]), .eof_o(eof_o[1]), .ovf_o(ovf_o[1])
  );

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [21:0]   exp_q0 [$];
  logic [21:0]   exp_q1 [$];
  logic [19:0]   frm [64];
  int            in_cnt = 0;
  logic          cur_drop = 1'b0;
  logic          force_drop = 1'b0;
  logic          ovf_exp = 1'b0;
  logic          ovf_nxt = 1'b0;
  logic          in_reset = 1'b1;
  logic          ramp_chk = 1'b0;
  int            ramp_idx = 0;
  int            last_in_cyc = 0;
  logic          stall_prev [2];
  logic [21:0]   hold_obs [2];
  int            first_vld [2];
  int            last_xfer [2];
  int            xfer_cnt [2];
  int            ovf_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd(input int pct);
    return int'($urandom_range(32'd99)) < pct;
  endfunction

  // Frame model: natural-order output j of the reordering instance is input position
  // (j mod 8)*8 + j/8; the pass-order instance returns input position j.
  task automatic model_in(input logic [W-1:0] re, input logic [W-1:0] im);
    int src;
    if (in_cnt == 0) cur_drop = force_drop;
    frm[in_cnt] = {re, im};
    in_cnt++;
    if (in_cnt == 64) begin
      in_cnt = 0;
      last_in_cyc = cyc;
      if (cur_drop) begin
        ovf_nxt = 1'b1;
      end else begin
        for (int j = 0; j < 64; j++) begin
          src = (j % 8) * 8 + j / 8;
          exp_q0.push_back({frm[src], j == 0, j == 63});
          exp_q1.push_back({frm[j], j == 0, j == 63});
        end
      end
    end
  endtask

  task automatic check_port(input int p);
    logic [21:0] obs;
    logic [21:0] exp_e;
    int          qsz;
    obs = {re_o[p], im_o[p], sof_o[p], eof_o[p]};
    if (in_reset) begin
      chk($sformatf("rst_zero%0d", p), 32'({vld_o[p], obs, ovf_o[p]}), 32'd0);
    end else begin
      if (stall_prev[p]) chk($sformatf("stable%0d", p), 32'({vld_o[p], obs}), 32'({1'b1, hold_obs[p]}));
      if (vld_o[p] && first_vld[p] < 0) first_vld[p] = cyc;
      if (vld_o[p] && rdy_i) begin
        qsz = (p == 0) ? exp_q0.size() : exp_q1.size();
        chk($sformatf("out_pending%0d", p), 32'(qsz != 0), 32'd1);
        if (qsz != 0) begin
          exp_e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("data%0d", p), 32'(obs), 32'(exp_e));
        end
        if (p == 0 && ramp_chk) begin
          chk("t1_ramp", 32'(re_o[0]), 32'(ramp_idx));
          ramp_idx++;
        end
        xfer_cnt[p]++;
        last_xfer[p] = cyc;
      end
      chk($sformatf("ovf%0d", p), 32'(ovf_o[p]), 32'(ovf_exp));
      ovf_cnt[p] += int'(ovf_o[p]);
    end
    stall_prev[p] = vld_o[p] && !rdy_i;
    hold_obs[p]   = obs;
  endtask

  task automatic step(input logic v, input logic [W-1:0] re, input logic [W-1:0] im, input logic r);
    vld_i = v;
    re_i  = re;
    im_i  = im;
    rdy_i = r;
    check_port(0);
    check_port(1);
    ovf_nxt = 1'b0;
    if (v) model_in(re, im);
    @(posedge clk);
    #1;
    cyc++;
    ovf_exp = ovf_nxt;
  endtask

  task automatic send_frame(input int mode, input int vld_pct, input int rdy_pct);
    int           k;
    int           kv;
    logic [W-1:0] re;
    logic [W-1:0] im;
    k = 0;
    while (k < 64) begin
      if (rnd(vld_pct)) begin
        case (mode)
          1: begin kv = (k % 8) * 8 + k / 8; re = W'(kv); im = W'(-kv); end
          2: begin re = W'(k); im = W'($urandom); end
          default: begin re = W'($urandom); im = W'($urandom); end
        endcase
        step(1'b1, re, im, rnd(rdy_pct));
        k++;
      end else begin
        step(1'b0, W'($urandom), W'($urandom), rnd(rdy_pct));
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !vld_o[0] && !vld_o[1]) break;
      step(1'b0, '0, '0, 1'b1);
    end
    chk("drain_done", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  task automatic clear_stats();
    for (int p = 0; p < 2; p++) begin
      first_vld[p] = -1;
      last_xfer[p] = 0;
      xfer_cnt[p]  = 0;
      ovf_cnt[p]   = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; re_i = '0; im_i = '0;
    for (int p = 0; p < 2; p++) begin
      stall_prev[p] = 1'b0;
      hold_obs[p]   = '0;
    end
    clear_stats();
    #1;
    repeat (3) step(1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    in_reset = 1'b0;
    repeat (2) step(1'b0, '0, '0, 1'b1);

    // Ramp frame placed in digit-reversed slots comes out as 0..63; check latency.
    clear_stats();
    ramp_chk = 1'b1;
    ramp_idx = 0;
    send_frame(1, 100, 100);
    drain();
    ramp_chk = 1'b0;
    chk("t1_latency", 32'(first_vld[0] - last_in_cyc), 32'd3);
    chk("t1_count", 32'(ramp_idx), 32'd64);

    // Natural-order input: pass-order instance returns it unchanged.
    clear_stats();
    send_frame(2, 100, 100);
    drain();
    chk("t2_count", 32'(xfer_cnt[1]), 32'd64);

    // Three back-to-back frames with a ready sink: no bubble, no overflow.
    clear_stats();
    repeat (3) send_frame(0, 100, 100);
    drain();
    chk("t3_count", 32'(xfer_cnt[0]), 32'd192);
    chk("t3_span", 32'(last_xfer[0] - first_vld[0] + 1), 32'd192);
    chk("t3_ovf", 32'(ovf_cnt[0] + ovf_cnt[1]), 32'd0);

    // Stalled sink while A, B, C arrive: C is dropped, A then B are delivered.
    clear_stats();
    repeat (2) send_frame(0, 100, 0);
    force_drop = 1'b1;
    send_frame(0, 100, 0);
    force_drop = 1'b0;
    repeat (8) step(1'b0, '0, '0, 1'b0);
    chk("t4_held", 32'(xfer_cnt[0]), 32'd0);
    drain();
    chk("t4_count", 32'(xfer_cnt[0]), 32'd128);
    chk("t4_ovf_reo", 32'(ovf_cnt[0]), 32'd1);
    chk("t4_ovf_nat", 32'(ovf_cnt[1]), 32'd1);

    // Random input gaps and random back-pressure over 20 frames.
    clear_stats();
    repeat (20) send_frame(0, 33, 50);
    drain();
    chk("t5_count", 32'(xfer_cnt[0]), 32'd1280);
    chk("t5_ovf", 32'(ovf_cnt[0] + ovf_cnt[1]), 32'd0);

    // Reset at input sample 30, then a clean frame.
    clear_stats();
    for (int i = 0; i < 30; i++) step(1'b1, W'($urandom), W'($urandom), 1'b1);
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    exp_q0.delete();
    exp_q1.delete();
    in_cnt = 0;
    ovf_exp = 1'b0;
    repeat (3) step(1'b0, '0, '0, 1'b1);
    rst_n = 1'b1;
    in_reset = 1'b0;
    step(1'b0, '0, '0, 1'b1);
    send_frame(0, 100, 100);
    drain();
    chk("t6_count", 32'(xfer_cnt[0]), 32'd64);
    chk("t6_ovf", 32'(ovf_cnt[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
